miriscv_lsu_ctrl: RTL

//  Load/store controller between miriscv decode/execute and the data-memory port (req/gnt/rvalid bus).

---
 rtl/miriscv_decode_pkg.sv | 13 +
 rtl/miriscv_lsu_align.sv | 71 +++++++
 rtl/miriscv_lsu_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/miriscv_decode_pkg.sv
// Decode-stage shared definitions used by the load/store path.
// MEM_ACCESS_* encode the access size and signedness carried with a
// memory instruction from decode into the LSU. Codes 5..7 are unused
// and are treated as illegal by the LSU.
package miriscv_decode_pkg;

    localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
    localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
    localparam logic [2:0] MEM_ACCESS_UHALF = 3'd3;
    localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational data alignment for the LSU.
// Request side : req_size/req_addr_lo/req_wdata -> byte enables,
//                replicated store data, misalignment/illegal-size flag.
// Response side: rsp_size/rsp_addr_lo/rsp_rdata -> sign/zero-extended
//                load data.
// Ports:
//   req_size    in  3   MEM_ACCESS_* code of the incoming access
//   req_addr_lo in  2   byte offset of the incoming access
//   req_wdata   in  32  store data, LSB-aligned
//   be          out 4   byte enables for the bus
//   wdata       out 32  store data replicated across all lanes
//   misalign    out 1   offset not aligned to size, or illegal size code
//   rsp_size    in  3   MEM_ACCESS_* code of the outstanding access
//   rsp_addr_lo in  2   byte offset of the outstanding access
//   rsp_rdata   in  32  raw bus read data
//   rdata       out 32  extended load result
module miriscv_lsu_align
    import miriscv_decode_pkg::*;
(
    input  logic [2:0]  req_size,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  rsp_size,
    input  logic [1:0]  rsp_addr_lo,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        be       = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (req_size)
            MEM_ACCESS_WORD: begin
                be       = 4'b1111;
                wdata    = req_wdata;
                misalign = |req_addr_lo;
            end
            MEM_ACCESS_HALF, MEM_ACCESS_UHALF: begin
                be       = 4'b0011 << {req_addr_lo[1], 1'b0};
                wdata    = {2{req_wdata[15:0]}};
                misalign = req_addr_lo[0];
            end
            MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: begin
                be       = 4'b0001 << req_addr_lo;
                wdata    = {4{req_wdata[7:0]}};
            end
            default: misalign = 1'b1;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rsp_rdata >> {rsp_addr_lo, 3'b000};

    always_comb begin
        rdata = rsp_rdata;
        case (rsp_size)
            MEM_ACCESS_HALF:  rdata = {{16{shifted[15]}}, shifted[15:0]};
            MEM_ACCESS_UHALF: rdata = {16'h0000, shifted[15:0]};
            MEM_ACCESS_BYTE:  rdata = {{24{shifted[7]}}, shifted[7:0]};
            MEM_ACCESS_UBYTE: rdata = {24'h000000, shifted[7:0]};
            default:          rdata = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu_ctrl.sv
// Load/store controller between execute and the data-memory port.
// Runs one access at a time over a req/gnt/rvalid bus, stalls the
// pipeline while busy, flags misaligned/illegal accesses and response
// timeouts, and returns extended load data.
// Ports:
//   clk_i, arstn_i          clock, async active-low reset
//   lsu_req_i/we/size/addr/wdata/kill   access request from EX
//   lsu_stall_req_o         hold the pipeline
//   lsu_valid_o/rdata_o     completion pulse and load result
//   lsu_misalign_o          misaligned or illegal size, no bus access
//   lsu_bus_err_o           response timeout
//   data_*                  data-memory bus
module miriscv_lsu_ctrl
    import miriscv_decode_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_kill_i,
    output logic        lsu_stall_req_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misalign_o,
    output logic        lsu_bus_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e           state_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [2:0]       size_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             kill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]       be_n;
    logic [31:0]      wdata_n;
    logic             misalign_n;
    logic [31:0]      rdata_ext;
    logic             start;
    logic             timeout_hit;
    logic             killed;

    miriscv_lsu_align u_align (
        .req_size    (lsu_size_i),
        .req_addr_lo (lsu_addr_i[1:0]),
        .req_wdata   (lsu_wdata_i),
        .be          (be_n),
        .wdata       (wdata_n),
        .misalign    (misalign_n),
        .rsp_size    (size_q),
        .rsp_addr_lo (addr_q[1:0]),
        .rsp_rdata   (data_rdata_i),
        .rdata       (rdata_ext)
    );

    assign start = (state_q == ST_IDLE) & lsu_req_i & ~lsu_kill_i & ~misalign_n;

    // The final permitted RESP cycle without rvalid is the timeout cycle;
    // a response arriving in that same cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) & (state_q == ST_RESP) & ~data_rvalid_i
                       & (cnt_q == CNT_LAST);

    // A kill arriving in the completion cycle suppresses it as well.
    assign killed = kill_q | lsu_kill_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                    if (start) begin
                        addr_q  <= lsu_addr_i;
                        we_q    <= lsu_we_i;
                        size_q  <= lsu_size_i;
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    kill_q <= kill_q | lsu_kill_i;
                    if (data_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    kill_q <= kill_q | lsu_kill_i;
                    if (data_rvalid_i || timeout_hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lsu_stall_req_o = start
                        | (state_q == ST_REQ)
                        | ((state_q == ST_RESP) & ~data_rvalid_i & ~timeout_hit);
        lsu_valid_o     = (state_q == ST_RESP) & data_rvalid_i & ~killed;
        lsu_bus_err_o   = timeout_hit & ~killed;
        lsu_misalign_o  = (state_q == ST_IDLE) & lsu_req_i & ~lsu_kill_i & misalign_n;
        lsu_rdata_o     = (lsu_valid_o & ~we_q) ? rdata_ext : '0;
    end

    assign data_req_o   = (state_q == ST_REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = {addr_q[31:2], 2'b00};
    assign data_wdata_o = wdata_q;

endmodule
